// File: rtl/detrust_pkg.sv
// rtl/detrust_pkg.sv - shared constants for the sequence trigger monitor
package detrust_pkg;

    localparam int NIB_W    = 4;
    localparam int GRP_NIBS = 4;
    localparam int GRP_W    = NIB_W * GRP_NIBS;

    typedef logic [1:0] fsm_t;

    localparam fsm_t IDLE  = 2'd0;
    localparam fsm_t ARMED = 2'd1;
    localparam fsm_t FIRED = 2'd2;

endpackage

// File: rtl/slot_match_stage.sv
// rtl/slot_match_stage.sv - one slot's masked nibble compare and group reduce
module slot_match_stage
    import detrust_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         hist_word,
    input  logic [DATA_W-1:0]         pattern,
    input  logic [DATA_W-1:0]         mask,
    output logic [DATA_W/GRP_W-1:0]   grp_match
);

    localparam int N_NIB = DATA_W / NIB_W;
    localparam int N_GRP = DATA_W / GRP_W;

    logic [DATA_W-1:0] diff;
    logic [N_NIB-1:0]  m1_d, m1_q;
    logic [N_GRP-1:0]  m2_d, m2_q;

    always_comb begin
        diff = (hist_word ^ pattern) & mask;
        for (int n = 0; n < N_NIB; n++) begin
            m1_d[n] = (diff[n*NIB_W +: NIB_W] == '0);
        end
        for (int g = 0; g < N_GRP; g++) begin
            m2_d[g] = &m1_q[g*GRP_NIBS +: GRP_NIBS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m1_q <= '0;
            m2_q <= '0;
        end else begin
            m1_q <= m1_d;
            m2_q <= m2_d;
        end
    end

    assign grp_match = m2_q;

endmodule

// File: rtl/seq_trigger_monitor.sv
// rtl/seq_trigger_monitor.sv - multi-cycle masked pattern sequence trigger with hit counter
module seq_trigger_monitor
    import detrust_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 2,
    parameter int  CNT_W  = 8,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] state,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_pattern,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              arm,
    input  logic              sticky_en,
    output logic              hit,
    output logic              trig,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              cfg_err
);

    localparam int N_GRP = DATA_W / GRP_W;

    logic [DATA_W-1:0] hist_q [DEPTH];
    logic [DATA_W-1:0] hist_d [DEPTH];
    logic [DATA_W-1:0] pat_q  [DEPTH];
    logic [DATA_W-1:0] pat_d  [DEPTH];
    logic [DATA_W-1:0] mask_q [DEPTH];
    logic [DATA_W-1:0] mask_d [DEPTH];
    logic [N_GRP-1:0]  grp_match [DEPTH];

    logic             raw_d, raw_q;
    fsm_t             fsm_d, fsm_q;
    logic [CNT_W-1:0] hit_cnt_d, hit_cnt_q;
    logic             cfg_err_d, cfg_err_q;
    logic             active;

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        slot_match_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .hist_word (hist_q[s]),
            .pattern   (pat_q[s]),
            .mask      (mask_q[s]),
            .grp_match (grp_match[s])
        );
    end

    // Slot DEPTH-1 always holds the newest sample.
    always_comb begin
        for (int s = 0; s < DEPTH - 1; s++) begin
            hist_d[s] = hist_q[s+1];
        end
        hist_d[DEPTH-1] = state;
    end

    always_comb begin
        pat_d     = pat_q;
        mask_d    = mask_q;
        cfg_err_d = cfg_we && (fsm_q != IDLE);
        if (cfg_we && (fsm_q == IDLE)) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (cfg_idx == IDX_W'(s)) begin
                    pat_d[s]  = cfg_pattern;
                    mask_d[s] = cfg_mask;
                end
            end
        end
    end

    always_comb begin
        raw_d = 1'b1;
        for (int s = 0; s < DEPTH; s++) begin
            raw_d = raw_d & (&grp_match[s]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                hist_q[s] <= '0;
                pat_q[s]  <= '0;
                mask_q[s] <= '1;
            end
            raw_q     <= 1'b0;
            fsm_q     <= IDLE;
            hit_cnt_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            mask_q    <= mask_d;
            raw_q     <= raw_d;
            fsm_q     <= fsm_d;
            hit_cnt_q <= hit_cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (arm) fsm_d = ARMED;
            ARMED: begin
                if (!arm) begin
                    fsm_d = IDLE;
                end else if (hit && sticky_en) begin
                    fsm_d = FIRED;
                end
            end
            FIRED:   if (!arm) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // arm is used combinationally so a disarm suppresses a hit in the same cycle.
    always_comb begin
        active = (fsm_q == ARMED) || (fsm_q == FIRED);
        hit    = raw_q && arm && active;
        trig   = (fsm_q == FIRED) || (!sticky_en && hit);
    end

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if ((fsm_q == IDLE) && arm) begin
            hit_cnt_d = '0;
        end else if (hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    assign hit_cnt = hit_cnt_q;
    assign cfg_err = cfg_err_q;

endmodule
